// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset/lock sequencer running on the free-running reference clock.
// Drives the PLL RST pin, holds the domain reset until LOCKED has been stable for
// LOCK_WAIT cycles, and re-resets the PLL (counting the event) on loss of lock.
// Optional feature macro: PLL_RST_SEQ_TIMEOUT_EN -- when defined, WAIT_LOCK retries
// the PLL reset after TIMEOUT cycles without lock; otherwise it waits indefinitely.
module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned LOCK_WAIT   = 1024,
  parameter int unsigned TIMEOUT     = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] relock_cnt
);

  localparam int unsigned MAX_HW  = (RST_HOLD > LOCK_WAIT) ? RST_HOLD : LOCK_WAIT;
  localparam int unsigned MAX_CNT = (MAX_HW > TIMEOUT) ? MAX_HW : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [1:0] ST_PLL_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_WAIT - 1);
`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
`endif

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;
  logic [1:0]             r_state;
  logic [1:0]             w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pll_rst;
  logic                   r_rst_out;
  logic                   r_ready;
  logic [7:0]             r_relock_cnt;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // Bring the asynchronous LOCKED into the reference clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_PLL_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a lock drop always wins over a completing count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == HOLD_LAST) begin
          w_next = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next = ST_STABLE;
        end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_next = ST_PLL_RST;
        end
`endif
      end
      ST_STABLE: begin
        if (!w_locked_s) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_cnt == WAIT_LAST) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!w_locked_s) begin
          w_next = ST_PLL_RST;
        end
      end
      default: begin
        w_next = ST_PLL_RST;
      end
    endcase
  end

  // Shared cycle counter (cleared on every state change) and outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_pll_rst    <= 1'b1;
      r_rst_out    <= 1'b1;
      r_ready      <= 1'b0;
      r_relock_cnt <= 8'd0;
    end else begin
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_pll_rst <= (w_next == ST_PLL_RST);
      r_rst_out <= (w_next != ST_RUN);
      r_ready   <= (w_next == ST_RUN);
      if ((r_state == ST_RUN) && (w_next == ST_PLL_RST) && (r_relock_cnt != 8'hFF)) begin
        r_relock_cnt <= r_relock_cnt + 8'd1;
      end
    end
  end

  assign pll_rst    = r_pll_rst;
  assign rst_out    = r_rst_out;
  assign ready      = r_ready;
  assign relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with SYNC_STAGES=2, RST_HOLD=4, LOCK_WAIT=8, TIMEOUT=32.
// Each table record drives {rst, locked} for n cycles and holds the outputs expected
// after every one of those clock edges.
module tb_pll_reset_seq;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned RST_HOLD    = 4;
  localparam int unsigned LOCK_WAIT   = 8;
  localparam int unsigned TIMEOUT     = 32;

  typedef struct packed {
    logic       p;
    logic       ro;
    logic       rdy;
    logic [7:0] rc;
  } exp_t;

  typedef struct {
    string      name;
    logic       r;
    logic       l;
    int         n;
    logic       p;
    logic       ro;
    logic       rdy;
    logic [7:0] rc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic [7:0] relock_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   step     = 0;
  exp_t sb[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_HOLD   (RST_HOLD),
    .LOCK_WAIT  (LOCK_WAIT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .rst_out   (rst_out),
    .ready     (ready),
    .relock_cnt(relock_cnt)
  );

  function automatic vec_t mk(input string name, input logic r, input logic l, input int n,
                              input logic p, input logic ro, input logic rdy, input int rc);
    vec_t v;
    v.name = name; v.r = r; v.l = l; v.n = n;
    v.p = p; v.ro = ro; v.rdy = rdy; v.rc = 8'(rc);
    return v;
  endfunction

  // Drive one input pair for n cycles; expectation queued at drive, checked after the edge.
  task automatic run_seg(input string name, input logic r, input logic l, input int n,
                         input logic p, input logic ro, input logic rdy, input logic [7:0] rc);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      rst    = r;
      locked = l;
      e.p = p; e.ro = ro; e.rdy = rdy; e.rc = rc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = exp_t'({pll_rst, rst_out, ready, relock_cnt});
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL %s step=%0d got pll_rst=%b rst_out=%b ready=%b relock_cnt=%0d want pll_rst=%b rst_out=%b ready=%b relock_cnt=%0d",
                 name, step, got.p, got.ro, got.rdy, got.rc, e.p, e.ro, e.rdy, e.rc);
      end
      step++;
    end
  endtask

  initial begin
    int rcb;
    int rca;

    // Power-up lock, lock loss in RUN, mid-operation reset, then two STABLE glitches
    // (the second lands on the very cycle the LOCK_WAIT count would complete).
    tbl_a.push_back(mk("pwr_rst",     1, 0, 3,  1, 1, 0, 0));
    tbl_a.push_back(mk("pwr_hold",    0, 0, 3,  1, 1, 0, 0));
    tbl_a.push_back(mk("pwr_wait",    0, 0, 7,  0, 1, 0, 0));
    tbl_a.push_back(mk("pwr_stable",  0, 1, 10, 0, 1, 0, 0));
    tbl_a.push_back(mk("pwr_run",     0, 1, 5,  0, 0, 1, 0));
    tbl_a.push_back(mk("loss_sync",   0, 0, 2,  0, 0, 1, 0));
    tbl_a.push_back(mk("loss_rst",    0, 0, 1,  1, 1, 0, 1));
    tbl_a.push_back(mk("loss_hold",   0, 1, 3,  1, 1, 0, 1));
    tbl_a.push_back(mk("loss_relock", 0, 1, 9,  0, 1, 0, 1));
    tbl_a.push_back(mk("loss_run",    0, 1, 4,  0, 0, 1, 1));
    tbl_a.push_back(mk("mid_rst",     1, 1, 1,  1, 1, 0, 0));
    tbl_a.push_back(mk("g_hold",      0, 1, 3,  1, 1, 0, 0));
    tbl_a.push_back(mk("g_wait",      0, 1, 5,  0, 1, 0, 0));
    tbl_a.push_back(mk("g_drop1",     0, 0, 1,  0, 1, 0, 0));
    tbl_a.push_back(mk("g_restart",   0, 1, 8,  0, 1, 0, 0));
    tbl_a.push_back(mk("g_drop2",     0, 0, 1,  0, 1, 0, 0));
    tbl_a.push_back(mk("g_relock",    0, 1, 10, 0, 1, 0, 0));
    tbl_a.push_back(mk("g_run",       0, 1, 4,  0, 0, 1, 0));

    // Locked held low after a reset: retry pulses with the timeout, one pulse without.
    tbl_b.push_back(mk("to_rst",      1, 0, 1,  1, 1, 0, 0));
    tbl_b.push_back(mk("to_hold",     0, 0, 3,  1, 1, 0, 0));
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    tbl_b.push_back(mk("to_low",      0, 0, 32, 0, 1, 0, 0));
    tbl_b.push_back(mk("to_retry",    0, 0, 4,  1, 1, 0, 0));
    tbl_b.push_back(mk("to_low2",     0, 0, 32, 0, 1, 0, 0));
    tbl_b.push_back(mk("to_retry2",   0, 0, 1,  1, 1, 0, 0));
`else
    tbl_b.push_back(mk("to_low",      0, 0, 80, 0, 1, 0, 0));
`endif

    rst    = 1'b1;
    locked = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl_a[i]) begin
      run_seg(tbl_a[i].name, tbl_a[i].r, tbl_a[i].l, tbl_a[i].n,
              tbl_a[i].p, tbl_a[i].ro, tbl_a[i].rdy, tbl_a[i].rc);
    end

    // Repeated lock loss from RUN: relock_cnt must saturate at 255.
    for (int k = 0; k < 260; k++) begin
      rcb = (k > 255) ? 255 : k;
      rca = (k + 1 > 255) ? 255 : k + 1;
      run_seg("sat_sync",   0, 0, 2, 0, 0, 1, 8'(rcb));
      run_seg("sat_rst",    0, 0, 1, 1, 1, 0, 8'(rca));
      run_seg("sat_hold",   0, 1, 3, 1, 1, 0, 8'(rca));
      run_seg("sat_relock", 0, 1, 9, 0, 1, 0, 8'(rca));
      run_seg("sat_run",    0, 1, 1, 0, 0, 1, 8'(rca));
    end

    foreach (tbl_b[i]) begin
      run_seg(tbl_b[i].name, tbl_b[i].r, tbl_b[i].l, tbl_b[i].n,
              tbl_b[i].p, tbl_b[i].ro, tbl_b[i].rdy, tbl_b[i].rc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Single-clock reset/lock sequencer sitting directly downstream of a PLL's LOCKED output and upstream of the per-domain reset synchronizers and logic.
- Drives the PLL's RST pin and produces a clean, held-off domain reset that releases only after LOCKED has been stable for a programmable time.
- On loss of lock it re-resets the PLL and counts relock events.
- Runs on the free-running input clock (pre-PLL), not on a PLL output.

Parameters:
- SYNC_STAGES, 2: flops in the `locked` synchronizer chain; minimum 2.
- RST_HOLD, 16: cycles `pll_rst` is held high per PLL reset pulse; minimum 1.
- LOCK_WAIT, 1024: consecutive cycles `locked_s` must stay high before the domain reset releases; minimum 1.
- TIMEOUT, 65536: cycles to wait for lock before retrying a PLL reset; minimum 2; used only with the optional feature.

Ports:
- clk  in  1  free-running reference clock (same net that feeds PLL CLKIN).
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL LOCKED, asynchronous to clk.
- pll_rst  out  1  to PLL RST.
- rst_out  out  1  domain reset request, active-high; the consumer re-synchronizes it into each PLL clock domain.
- ready  out  1  high while the PLL is locked and the domain is out of reset.
- relock_cnt  out  8  count of lock-loss events seen in RUN, saturating at 255.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clk`, `rst`).
- Synchronizer: `locked` passes through SYNC_STAGES flops, giving `locked_s`. Latency from a `locked` change to `locked_s` is SYNC_STAGES cycles. All decisions use `locked_s` only.
- Counter: one shared cycle counter, width = clog2 of the largest of RST_HOLD, LOCK_WAIT, TIMEOUT, plus 1. Cleared on every state change.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state transition.
- Reset: when `rst`=1 at a clock edge, on that edge:
  - state <= PLL_RST, counter <= 0, sync chain <= 0.
  - pll_rst=1, rst_out=1, ready=0, relock_cnt=0.
  - The same applies if `rst` is asserted mid-operation in any state.
- PLL_RST:
  - pll_rst=1, rst_out=1, ready=0.
  - After exactly RST_HOLD cycles in this state, go to WAIT_LOCK.
  - `locked_s` is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0, rst_out=1, ready=0.
  - If `locked_s`=1, go to STABLE.
  - The timeout path exists only with the optional feature.
- STABLE:
  - pll_rst=0, rst_out=1, ready=0.
  - If `locked_s`=0, go back to WAIT_LOCK. A glitch restarts the full LOCK_WAIT count.
  - After LOCK_WAIT consecutive cycles with `locked_s`=1, go to RUN.
- RUN:
  - pll_rst=0, rst_out=0, ready=1.
  - If `locked_s`=0, go to PLL_RST and increment relock_cnt (saturating at 255) on that same edge.
  - Every exit from RUN goes through PLL_RST.
- Simultaneous events:
  - `rst` has priority over every transition.
  - In STABLE, a `locked_s` drop on the same cycle the count completes is treated as a drop (go to WAIT_LOCK).
- `rst_out` is never low while `pll_rst` is high.
- `ready` equals `~rst_out` at all times.

Optional Feature:
- Macro: PLL_RST_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT_LOCK, if `locked_s` stays 0 for TIMEOUT cycles, go to PLL_RST (retry).
  - relock_cnt is not incremented by timeouts.
  - `locked_s`=1 on the final timeout cycle has priority: go to STABLE.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - The TIMEOUT parameter is accepted but unused.

Test Plan (SYNC_STAGES=2, RST_HOLD=4, LOCK_WAIT=8, TIMEOUT=32):
- Power-up lock: hold rst for 3 cycles, release; raise `locked` 10 cycles later and hold it.
  - pll_rst high for exactly 4 cycles after the rst release.
  - rst_out falls and ready rises exactly 2+8 cycles after the synchronized edge plus the 1-cycle state entry.
  - relock_cnt=0.
- Lock glitch in STABLE: drop `locked` for 1 cycle after 5 stable cycles.
  - Returns to WAIT_LOCK.
  - rst_out stays 1 until a fresh 8 consecutive locked cycles.
  - relock_cnt=0.
- Lock loss in RUN: drop `locked` for 3 cycles.
  - pll_rst rises 3 cycles after the drop (2 sync + 1) and is held 4 cycles.
  - rst_out=1, relock_cnt=1.
  - Re-lock returns to RUN.
- Saturation: 260 lock-loss/relock cycles -> relock_cnt stops at 255.
- Timeout (PLL_RST_SEQ_TIMEOUT_EN defined): `locked` held 0.
  - pll_rst pulses 4 cycles high, 32 cycles low, repeating.
  - relock_cnt stays 0.
  - Without the macro: a single 4-cycle pulse, then low forever.
- Mid-operation reset: assert rst for 1 cycle while in RUN.
  - Next edge: pll_rst=1, rst_out=1, ready=0, relock_cnt=0.
  - Full sequence restarts.
